alu_seq: RTL and testbench

- Parametrised, multi-cycle successor to the combinational opcode ALU.
- Same opcode set: ADD, SUB, MUL, DIV, VAR (remainder).
- Operand width is generic. Results are exact (double width).
- MUL and DIV/VAR run iteratively; ADD/SUB complete in a single cycle.
- Sits between the instruction source and the writeback stage, with valid/ready handshakes on both sides.

---
 rtl/alu_seq_if.sv | 33 +++
 rtl/alu_seq.sv | 157 +++++++++++++++
 tb/tb_alu_seq.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Instruction/result bus between the instruction source, alu_seq and the writeback stage.
//
// Handshake rules (both sides):
//   A transfer happens on a rising clk edge where valid && ready are both high.
//   valid must not depend combinationally on ready, and the payload must stay
//   stable while valid is high and ready is low.
//   ready may be driven combinationally.
interface alu_seq_if #(
  parameter int WIDTH = 8,
  parameter int OPC_W = 3
);
  logic               in_valid;
  logic               in_ready;
  logic [OPC_W-1:0]   opc;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;
  logic               err;

  // Instruction source / writeback side.
  modport master (
    output in_valid, opc, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, err
  );

  // ALU side.
  modport slave (
    input  in_valid, opc, op_a, op_b, out_ready,
    output in_ready, out_valid, result, err
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle opcode ALU: ADD/SUB finish in one cycle, MUL (shift-add) and
// DIV/VAR (restoring division) iterate one bit per clock over WIDTH cycles.
// Results are full 2*WIDTH-bit values held until the consumer accepts them.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int OPC_W = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_seq_if.slave    bus,
  output logic [1:0]  state_o
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_MUL = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_DIV = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_VAR = OPC_W'(4);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [OPC_W-1:0]   opc_q, opc_d;
  logic [WIDTH-1:0]   b_q, b_d;       // multiplicand or divisor
  logic [WIDTH-1:0]   rem_q, rem_d;   // upper product half or partial remainder
  logic [WIDTH-1:0]   quo_q, quo_d;   // multiplier/lower product or dividend/quotient
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               err_q, err_d;

  // One iteration of both datapaths; the FSM picks the one matching opc_q.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   iter_rem, iter_quo;

  // Shift-add multiply step and restoring-divide step.
  always_comb begin
    mul_sum   = {1'b0, rem_q} + (quo_q[0] ? {1'b0, b_q} : '0);
    div_shift = {rem_q, quo_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, b_q};
    div_diff  = div_shift[WIDTH-1:0] - b_q;
    if (opc_q == OP_MUL) begin
      iter_rem = mul_sum[WIDTH:1];
      iter_quo = {mul_sum[0], quo_q[WIDTH-1:1]};
    end else begin
      iter_rem = div_ge ? div_diff : div_shift[WIDTH-1:0];
      iter_quo = {quo_q[WIDTH-2:0], div_ge};
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opc_d    = opc_q;
    b_d      = b_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          opc_d = bus.opc;
          b_d   = bus.op_b;
          rem_d = '0;
          quo_d = bus.op_a;
          cnt_d = CW'(WIDTH);
          err_d = 1'b0;
          case (bus.opc)
            OP_ADD: begin
              result_d = {{WIDTH{1'b0}}, bus.op_a} + {{WIDTH{1'b0}}, bus.op_b};
              state_d  = S_DONE;
            end
            OP_SUB: begin
              result_d = {{WIDTH{1'b0}}, bus.op_a} - {{WIDTH{1'b0}}, bus.op_b};
              state_d  = S_DONE;
            end
            OP_MUL: state_d = S_CALC;
            OP_DIV, OP_VAR: begin
              if (bus.op_b == '0) begin
                // Divide by zero: all-ones quotient, dividend as remainder.
                result_d = (bus.opc == OP_DIV) ? {{WIDTH{1'b0}}, {WIDTH{1'b1}}}
                                               : {{WIDTH{1'b0}}, bus.op_a};
                err_d    = 1'b1;
                state_d  = S_DONE;
              end else begin
                state_d = S_CALC;
              end
            end
            default: begin
              result_d = '0;
              err_d    = 1'b1;
              state_d  = S_DONE;
            end
          endcase
        end
      end
      S_CALC: begin
        rem_d = iter_rem;
        quo_d = iter_quo;
        if (cnt_q == CW'(1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
          err_d   = 1'b0;
          if (opc_q == OP_MUL)      result_d = {iter_rem, iter_quo};
          else if (opc_q == OP_DIV) result_d = {{WIDTH{1'b0}}, iter_quo};
          else                      result_d = {{WIDTH{1'b0}}, iter_rem};
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      opc_q    <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opc_q    <= opc_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.err       = err_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH=8: directed vector table, random operations
// checked against an arithmetic reference, backpressure and mid-op reset.
module tb_alu_seq;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] state_dbg;

  // Clock
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W), .OPC_W(3)) bus ();

  alu_seq #(.WIDTH(W), .OPC_W(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard: {err, result} and expected latency per accepted instruction.
  logic [2*W:0] exp_q[$];
  int           lat_q[$];

  typedef struct {
    logic [2:0]     opc;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] res;
    logic           err;
    int             lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [2*W:0] model(input logic [2:0] opc, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [2*W-1:0] za, zb;
    za = {{W{1'b0}}, a};
    zb = {{W{1'b0}}, b};
    case (opc)
      3'd0:    return {1'b0, za + zb};
      3'd1:    return {1'b0, za - zb};
      3'd2:    return {1'b0, za * zb};
      3'd3:    return (b == 0) ? {1'b1, {W{1'b0}}, {W{1'b1}}} : {1'b0, za / zb};
      3'd4:    return (b == 0) ? {1'b1, za} : {1'b0, za % zb};
      default: return {1'b1, {(2*W){1'b0}}};
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] opc, input logic [W-1:0] b);
    if (opc == 3'd2 || ((opc == 3'd3 || opc == 3'd4) && b != 0)) return W + 1;
    return 1;
  endfunction

  // Driver: waits for in_ready, presents one instruction, records the expectation.
  task automatic send(input logic [2:0] opc, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2*W:0] exp, input int lat);
    int guard = 0;
    while (!bus.in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) begin
      check("send_in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.opc      = opc;
    bus.op_a     = a;
    bus.op_b     = b;
    exp_q.push_back(exp);
    lat_q.push_back(lat);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.opc      = 3'($urandom_range(0, 7));
    bus.op_a     = W'($urandom_range(0, 255));
    bus.op_b     = W'($urandom_range(0, 255));
  endtask

  // Monitor: counts cycles to out_valid, compares against the scoreboard,
  // holds out_ready low for 'stall' cycles, then completes the handshake.
  task automatic collect(input int stall);
    int           cyc = 0;
    int           rdy_bad = 0;
    int           unstable = 0;
    int           exp_lat;
    logic [2*W:0] exp, held;
    if (exp_q.size() == 0) begin
      check("sb_nonempty", exp_q.size(), 32'd1);
      return;
    end
    exp     = exp_q.pop_front();
    exp_lat = lat_q.pop_front();
    do begin
      @(negedge clk);
      cyc++;
      if (!bus.out_valid) begin
        if (bus.in_ready) rdy_bad++;
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.opc      = 3'($urandom_range(0, 7));
      end
    end while (!bus.out_valid && cyc < 100);
    check("latency", cyc, exp_lat);
    check("in_ready_busy", rdy_bad, 0);
    check("result_err", {15'd0, bus.err, bus.result}, {15'd0, exp});
    held = {bus.err, bus.result};
    if (stall > 0) begin
      repeat (stall) begin
        @(negedge clk);
        bus.in_valid = 1'($urandom_range(0, 1));
        if (!bus.out_valid || bus.in_ready || ({bus.err, bus.result} !== held)) unstable++;
      end
      check("hold_stable", unstable, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("release_valid_ready", {30'd0, bus.out_valid, bus.in_ready}, 32'b01);
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]   r_opc;
    logic [W-1:0] r_a, r_b;
    int           stray;

    vecs[0]  = '{3'd0, 8'd200, 8'd100, 16'h012C, 1'b0, 1};
    vecs[1]  = '{3'd1, 8'd5,   8'd7,   16'hFFFE, 1'b0, 1};
    vecs[2]  = '{3'd2, 8'd255, 8'd255, 16'hFE01, 1'b0, 9};
    vecs[3]  = '{3'd3, 8'd200, 8'd7,   16'h001C, 1'b0, 9};
    vecs[4]  = '{3'd4, 8'd200, 8'd7,   16'h0004, 1'b0, 9};
    vecs[5]  = '{3'd3, 8'd9,   8'd0,   16'h00FF, 1'b1, 1};
    vecs[6]  = '{3'd4, 8'd9,   8'd0,   16'h0009, 1'b1, 1};
    vecs[7]  = '{3'd6, 8'd9,   8'd3,   16'h0000, 1'b1, 1};
    vecs[8]  = '{3'd0, 8'd255, 8'd255, 16'h01FE, 1'b0, 1};
    vecs[9]  = '{3'd1, 8'd7,   8'd5,   16'h0002, 1'b0, 1};
    vecs[10] = '{3'd2, 8'd13,  8'd11,  16'h008F, 1'b0, 9};
    vecs[11] = '{3'd3, 8'd255, 8'd1,   16'h00FF, 1'b0, 9};
    vecs[12] = '{3'd4, 8'd255, 8'd16,  16'h000F, 1'b0, 9};
    vecs[13] = '{3'd3, 8'd3,   8'd200, 16'h0000, 1'b0, 9};
    vecs[14] = '{3'd7, 8'd5,   8'd5,   16'h0000, 1'b1, 1};
    vecs[15] = '{3'd2, 8'd77,  8'd0,   16'h0000, 1'b0, 9};

    // Reset
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.opc       = '0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("rst_result",    {16'd0, bus.result},    32'd0);
    check("rst_err",       {31'd0, bus.err},       32'd0);
    check("rst_state",     {30'd0, state_dbg},     32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 16; i++) begin
      send(vecs[i].opc, vecs[i].a, vecs[i].b, {vecs[i].err, vecs[i].res}, vecs[i].lat);
      collect(i % 3);
    end

    // Random operations against the arithmetic reference
    for (int i = 0; i < 40; i++) begin
      r_opc = 3'($urandom_range(0, 7));
      r_a   = W'($urandom_range(0, 255));
      r_b   = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(0, 255));
      send(r_opc, r_a, r_b, model(r_opc, r_a, r_b), model_lat(r_opc, r_b));
      collect($urandom_range(0, 2));
    end

    // Backpressure then back-to-back issue
    send(3'd0, 8'd1, 8'd2, {1'b0, 16'h0003}, 1);
    collect(5);
    send(3'd2, 8'd3, 8'd4, {1'b0, 16'h000C}, 9);
    collect(0);

    // Reset in the middle of a multiply
    send(3'd2, 8'd255, 8'd255, {1'b0, 16'hFE01}, 9);
    repeat (4) @(negedge clk);
    check("mid_calc_state", {30'd0, state_dbg}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_result",    {16'd0, bus.result},    32'd0);
    check("midrst_err",       {31'd0, bus.err},       32'd0);
    check("midrst_state",     {30'd0, state_dbg},     32'd0);
    exp_q.delete();
    lat_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    stray = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.out_valid) stray++;
    end
    check("no_stale_output", stray, 0);
    send(3'd1, 8'd10, 8'd3, {1'b0, 16'h0007}, 1);
    collect(1);

    check("sb_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
